// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave / command RAM pair.
// Holds the frame layout, the two-bit command codes carried in frame[9:8],
// and the slave FSM state encoding so assertions in either block can refer
// to one definition.
package spi_pkg;

  localparam int FRAME_W = 10;
  localparam int BYTE_W  = 8;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } spi_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHK_CMD   = 3'd1,
    ST_WRITE     = 3'd2,
    ST_READ_ADD  = 3'd3,
    ST_READ_DATA = 3'd4
  } spi_slave_state_e;

  function automatic spi_cmd_e frame_cmd(input logic [FRAME_W-1:0] frame);
    return spi_cmd_e'(frame[FRAME_W-1:FRAME_W-2]);
  endfunction

endpackage

// File: rtl/spi_ram_array.sv
// Byte storage for spi_ram.
// One synchronous write port and one synchronous read port with enable.
// Contents are never reset, so they survive rst_n; rdata holds between reads.
// Ports:
//   clk    in   clock, rising edge
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write byte
//   re     in   read enable, rdata loads mem[raddr] on the edge
//   raddr  in   read address
//   rdata  out  last byte read
module spi_ram_array #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/spi_ram.sv
// Command-decoding byte memory sitting behind the SPI slave.
// Each valid 10-bit frame is {cmd[1:0], payload[7:0]}: address frames arm
// the matching data frame; a data frame without a preceding address frame
// still executes but raises seq_err. Read bytes go back on dout/tx_valid.
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   din       in   frame from the slave
//   rx_valid  in   din valid, single-cycle pulse
//   dout      out  read byte, held while tx_valid is low
//   tx_valid  out  dout valid, single-cycle pulse
//   seq_err   out  single-cycle pulse on out-of-order or out-of-range access
module spi_ram
  import spi_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [FRAME_W-1:0]   din,
  input  logic                 rx_valid,
  output logic [BYTE_W-1:0]    dout,
  output logic                 tx_valid,
  output logic                 seq_err
);

  function automatic logic addr_in_range(input logic [ADDR_SIZE-1:0] addr);
    return {{(32-ADDR_SIZE){1'b0}}, addr} < 32'(MEM_DEPTH);
  endfunction

  spi_cmd_e             cmd_p0;
  logic [BYTE_W-1:0]    payload_p0;
  logic [ADDR_SIZE-1:0] addr_p0;
  logic                 wr_in_range_p0;
  logic                 rd_in_range_p0;
  logic                 mem_we_p0;
  logic                 mem_re_p0;

  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic                 wr_armed;
  logic                 rd_armed;
  // Forces dout to zero after reset and after an out-of-range read, since
  // the array's read register is not reset and is not loaded in that case.
  logic                 dout_zero_p1;
  logic [BYTE_W-1:0]    mem_rdata_p1;

  // ---- stage p0: frame decode, memory port controls ----
  always_comb begin
    cmd_p0         = frame_cmd(din);
    payload_p0     = din[BYTE_W-1:0];
    addr_p0        = din[ADDR_SIZE-1:0];
    wr_in_range_p0 = addr_in_range(wr_addr);
    rd_in_range_p0 = addr_in_range(rd_addr);
    mem_we_p0      = rx_valid && (cmd_p0 == CMD_WR_DATA) && wr_in_range_p0;
    mem_re_p0      = rx_valid && (cmd_p0 == CMD_RD_DATA) && rd_in_range_p0;
  end

  spi_ram_array #(
    .DEPTH  (MEM_DEPTH),
    .ADDR_W (ADDR_SIZE)
  ) u_array (
    .clk   (clk),
    .we    (mem_we_p0),
    .waddr (wr_addr),
    .wdata (payload_p0),
    .re    (mem_re_p0),
    .raddr (rd_addr),
    .rdata (mem_rdata_p1)
  );

  // ---- stage p1: command state and output pulses ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr      <= '0;
      rd_addr      <= '0;
      wr_armed     <= 1'b0;
      rd_armed     <= 1'b0;
      tx_valid     <= 1'b0;
      seq_err      <= 1'b0;
      dout_zero_p1 <= 1'b1;
    end else begin
      tx_valid <= 1'b0;
      seq_err  <= 1'b0;
      if (rx_valid) begin
        case (cmd_p0)
          CMD_WR_ADDR: begin
            wr_addr  <= addr_p0;
            wr_armed <= 1'b1;
          end
          CMD_WR_DATA: begin
            wr_armed <= 1'b0;
            seq_err  <= !wr_armed || !wr_in_range_p0;
          end
          CMD_RD_ADDR: begin
            rd_addr  <= addr_p0;
            rd_armed <= 1'b1;
          end
          CMD_RD_DATA: begin
            rd_armed     <= 1'b0;
            tx_valid     <= 1'b1;
            dout_zero_p1 <= !rd_in_range_p0;
            seq_err      <= !rd_armed || !rd_in_range_p0;
          end
          default: ;
        endcase
      end
    end
  end

  assign dout = dout_zero_p1 ? '0 : mem_rdata_p1;

endmodule

// File: tb/tb_spi_ram.sv
module tb_spi_ram;
  import spi_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_valid = 1'b0;
  logic [9:0] din = '0;
  logic [7:0] dout;
  logic       tx_valid;
  logic       seq_err;

  spi_ram dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .rx_valid (rx_valid),
    .dout     (dout),
    .tx_valid (tx_valid),
    .seq_err  (seq_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic       tv;
    logic [7:0] d;
    logic       err;
  } exp_t;

  exp_t q[$];

  logic [7:0] m_mem [256];
  logic [7:0] m_wa, m_ra, m_dout;
  bit         m_warm, m_rarm;

  task automatic model_reset();
    m_wa = 8'h00; m_ra = 8'h00; m_dout = 8'h00;
    m_warm = 1'b0; m_rarm = 1'b0;
    q.delete();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every output pulse must match the oldest expectation, at the
  // cycle it was scheduled for.
  always @(negedge clk) begin : mon
    exp_t e;
    while (q.size() != 0 && q[0].c < cyc) begin
      e = q.pop_front();
      total++; bad++;
      $display("FAIL missing_output at cyc=%0d: got nothing expected tv=%b dout=%h err=%b",
               e.c, e.tv, e.d, e.err);
    end
    if (rst_n && (tx_valid || seq_err)) begin
      total++;
      if (q.size() == 0 || q[0].c != cyc) begin
        bad++;
        $display("FAIL unexpected_output cyc=%0d: got tv=%b dout=%h err=%b expected no pulse",
                 cyc, tx_valid, dout, seq_err);
      end else begin
        e = q.pop_front();
        if (tx_valid !== e.tv || dout !== e.d || seq_err !== e.err) begin
          bad++;
          $display("FAIL output cyc=%0d: got tv=%b dout=%h err=%b expected tv=%b dout=%h err=%b",
                   cyc, tx_valid, dout, seq_err, e.tv, e.d, e.err);
        end
      end
    end
  end

  // Drive one frame; the expected pulse comes from the model, or from the
  // hand-computed values when hand=1.
  task automatic frame(input logic [9:0] f, input bit hand = 1'b0, input logic htv = 1'b0,
                       input logic [7:0] hd = 8'h00, input logic herr = 1'b0);
    logic tv, err;
    logic [7:0] d;
    @(negedge clk);
    din = f;
    rx_valid = 1'b1;
    tv = 1'b0; err = 1'b0;
    case (f[9:8])
      2'b00: begin m_wa = f[7:0]; m_warm = 1'b1; end
      2'b01: begin m_mem[m_wa] = f[7:0]; err = !m_warm; m_warm = 1'b0; end
      2'b10: begin m_ra = f[7:0]; m_rarm = 1'b1; end
      default: begin m_dout = m_mem[m_ra]; err = !m_rarm; m_rarm = 1'b0; tv = 1'b1; end
    endcase
    d = m_dout;
    if (hand) begin tv = htv; d = hd; err = herr; end
    if (tv || err) q.push_back('{cyc + 1, tv, d, err});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      din = 10'($urandom);
      rx_valid = 1'b0;
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    #2;
    rx_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_seq_err", 32'(seq_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [1:0] rc;
    logic [7:0] rp;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_dout", 32'(dout), 32'd0);
    chk("reset_tx_valid", 32'(tx_valid), 32'd0);
    chk("reset_seq_err", 32'(seq_err), 32'd0);
    rst_n = 1'b1;

    // Fill memory with a known pattern: mem[i] = i ^ 0x5A.
    for (int i = 0; i < 256; i++) begin
      frame({2'b00, 8'(i)});
      frame({2'b01, 8'(i) ^ 8'h5A});
    end
    idle(2);

    // Basic write then read.
    frame(10'h005);
    frame(10'h1A5);
    frame(10'h205);
    frame(10'h3FF, 1'b1, 1'b1, 8'hA5, 1'b0);
    idle(2);

    // Unarmed read after reset, then async reset while the pulse is high.
    reset_pulse();
    @(negedge clk);
    din = 10'h300;
    rx_valid = 1'b1;
    @(posedge clk);
    #2;
    chk("unarmed_rd_tx_valid", 32'(tx_valid), 32'd1);
    chk("unarmed_rd_dout", 32'(dout), 32'h5A);
    chk("unarmed_rd_seq_err", 32'(seq_err), 32'd1);
    rx_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_rst_dout", 32'(dout), 32'd0);
    chk("async_rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("async_rst_seq_err", 32'(seq_err), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Memory retained across reset.
    frame(10'h0FF);
    frame(10'h13C);
    reset_pulse();
    frame(10'h2FF);
    frame(10'h312, 1'b1, 1'b1, 8'h3C, 1'b0);
    idle(1);

    // Back-to-back reads after one address: second one is unarmed.
    frame(10'h207);
    frame(10'h300, 1'b1, 1'b1, 8'h5D, 1'b0);
    frame(10'h300, 1'b1, 1'b1, 8'h5D, 1'b1);
    idle(2);

    // Reset mid-sequence clears addresses and armed flags.
    frame(10'h010);
    frame(10'h220);
    reset_pulse();
    frame(10'h300, 1'b1, 1'b1, 8'h5A, 1'b1);
    frame(10'h199, 1'b1, 1'b0, 8'h5A, 1'b1);
    frame(10'h200);
    frame(10'h300, 1'b1, 1'b1, 8'h99, 1'b0);
    idle(1);

    // Read one cycle after a write to the same address.
    frame(10'h230);
    frame(10'h030);
    frame(10'h1E7);
    frame(10'h300, 1'b1, 1'b1, 8'hE7, 1'b0);
    idle(1);

    // Address overwrite while armed is not an error.
    frame(10'h240);
    frame(10'h241);
    frame(10'h300, 1'b1, 1'b1, 8'h1B, 1'b0);
    frame(10'h050);
    frame(10'h051);
    frame(10'h1C3);
    frame(10'h251);
    frame(10'h300, 1'b1, 1'b1, 8'hC3, 1'b0);
    frame(10'h250);
    frame(10'h300, 1'b1, 1'b1, 8'h0A, 1'b0);
    idle(2);

    // Random command stream with gaps, checked against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle(1);
      end else begin
        rc = 2'($urandom_range(0, 3));
        rp = 8'($urandom);
        frame({rc, rp});
      end
    end
    idle(4);

    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
